// File: rtl/sram_responder.sv
// Purpose : cycle-accurate responder for a 16-bit async-style external SRAM bus (write commit, delayed read return on DQ).
// Latency : writes commit at the sampling edge; read data is driven from just after edge k+READ_LAT-1 for an address sampled at edge k.
// Backpres: none; a read is launched on every WE_N=1 edge, and any write flushes all in-flight reads.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset (array contents are not reset)
//   SRAM_DQ    bidirectional data; driven only while rd_valid, otherwise high-Z
//   SRAM_ADDR  word address; only the low MEM_AW bits select the word (upper bits alias)
//   SRAM_WE_N  0 = write this cycle, 1 = read this cycle
//   rd_valid   responder is driving SRAM_DQ this cycle
//   busy       any read is in the latency pipe
//   err        sticky: an in-flight read was discarded by a write
//   rd_cnt     completed reads, saturating   (SRAM_RESP_STATS_EN only, else 0)
//   wr_cnt     committed writes, saturating  (SRAM_RESP_STATS_EN only, else 0)
//
// Optional feature macro: SRAM_RESP_STATS_EN enables the rd_cnt/wr_cnt counters.

module sram_responder #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int MEM_AW   = 18,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   input  logic [ADDR_W-1:0] SRAM_ADDR,
   input  logic              SRAM_WE_N,
   output logic              rd_valid,
   output logic              busy,
   output logic              err,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
);

   localparam int DEPTH = 2 ** MEM_AW;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [MEM_AW-1:0]   idx;
   logic [READ_LAT-1:0] pipe_vld;
   logic [DATA_W-1:0]   pipe_dat [READ_LAT];
   logic                unused_addr;

   assign idx         = SRAM_ADDR[MEM_AW-1:0];
   // Upper address bits are intentionally ignored (aliasing).
   assign unused_addr = ^SRAM_ADDR;

   // Word array: no reset, contents survive rst. Writes are blocked while
   // in reset so the responder stays inert until released.
   always_ff @(posedge clk) begin
      if (rst && !SRAM_WE_N) begin
         mem[idx] <= SRAM_DQ;
      end
   end

   // Data side of the pipe. Data is captured at launch so a later write to
   // the same word cannot change a read already in flight; the valid bits
   // decide whether a stage means anything.
   always_ff @(posedge clk) begin
      pipe_dat[0] <= mem[idx];
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_dat[i] <= pipe_dat[i-1];
      end
   end

   // Valid side of the pipe: a write edge wipes every stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld <= '0;
      end else if (!SRAM_WE_N) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= 1'b1;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
         end
      end
   end

   // Any valid stage at a write edge is a read that will never be returned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (!SRAM_WE_N && (|pipe_vld)) begin
         err <= 1'b1;
      end
   end

   // Drive is qualified by WE_N combinationally so the bus is released in
   // the same cycle the initiator turns it around for a write.
   assign rd_valid = pipe_vld[READ_LAT-1] & SRAM_WE_N;
   assign busy     = |pipe_vld;
   assign SRAM_DQ  = rd_valid ? pipe_dat[READ_LAT-1] : {DATA_W{1'bz}};

`ifdef SRAM_RESP_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_valid && (rd_cnt != 16'hFFFF)) begin
            rd_cnt <= rd_cnt + 16'd1;
         end
         if (!SRAM_WE_N && (wr_cnt != 16'hFFFF)) begin
            wr_cnt <= wr_cnt + 16'd1;
         end
      end
   end
`else
   assign rd_cnt = 16'h0000;
   assign wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Purpose : self-checking bench for sram_responder (MEM_AW=4 so aliasing is exercised, READ_LAT=2).
// Latency : driver issues one bus operation per clock; monitor checks outputs every falling edge.
// Backpres: none; expected reads are queued at launch and popped when due, writes flush the queue.

module tb_sram_responder;

   localparam int ADDR_W   = 18;
   localparam int DATA_W   = 16;
   localparam int MEM_AW   = 4;
   localparam int READ_LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   wire  [DATA_W-1:0] sram_dq;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_we_n;
   logic [DATA_W-1:0] dq_dat;
   logic              rd_valid;
   logic              busy;
   logic              err;
   logic [15:0]       rd_cnt;
   logic [15:0]       wr_cnt;

   // The bench owns the bus only while requesting a write.
   assign sram_dq = sram_we_n ? {DATA_W{1'bz}} : dq_dat;

   sram_responder #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MEM_AW  (MEM_AW),
      .READ_LAT(READ_LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .SRAM_DQ  (sram_dq),
      .SRAM_ADDR(sram_addr),
      .SRAM_WE_N(sram_we_n),
      .rd_valid (rd_valid),
      .busy     (busy),
      .err      (err),
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [DATA_W-1:0] data;
      int                due;   // edge at which the initiator samples it
   } rd_t;

   logic [DATA_W-1:0] mem_m [2**MEM_AW];
   rd_t               exp_q[$];
   logic              err_exp;
   logic [15:0]       wr_exp;
   logic [15:0]       rd_exp;
   int                cyc;
   int                n_chk;
   int                n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, cyc);
      end
   endtask

   // One bus cycle: present the operation, let the edge happen, then apply
   // the operation's effect to the model.
   task automatic step(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      rd_t r;
      sram_we_n = !wr;
      sram_addr = a;
      dq_dat    = d;
      @(posedge clk);
      cyc++;
      if (rst) begin
         if (wr) begin
            mem_m[a[MEM_AW-1:0]] = d;
            if (exp_q.size() != 0) err_exp = 1'b1;
            exp_q.delete();
            if (wr_exp != 16'hFFFF) wr_exp++;
         end else begin
            r.data = mem_m[a[MEM_AW-1:0]];
            r.due  = cyc + READ_LAT;
            exp_q.push_back(r);
         end
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      exp_q.delete();
      err_exp = 1'b0;
      wr_exp  = '0;
      repeat (n) step(1'b0, sram_addr, '0);
      rst = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic        exp_vld;
      logic [15:0] exp_rd;
      logic [15:0] exp_wr;
      if (!rst) rd_exp = '0;
`ifdef SRAM_RESP_STATS_EN
      exp_rd = rd_exp;
      exp_wr = wr_exp;
`else
      exp_rd = 16'h0000;
      exp_wr = 16'h0000;
`endif
      chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      chk("err", {31'd0, err}, {31'd0, err_exp});
      chk("rd_cnt", {16'd0, rd_cnt}, {16'd0, exp_rd});
      chk("wr_cnt", {16'd0, wr_cnt}, {16'd0, exp_wr});
      exp_vld = rst && sram_we_n && (exp_q.size() != 0) && (exp_q[0].due == cyc + 1);
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_vld});
      if (exp_vld) begin
         if (rd_valid) chk("rd_data", {16'd0, sram_dq}, {16'd0, exp_q[0].data});
         void'(exp_q.pop_front());
         if (rd_exp != 16'hFFFF) rd_exp++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b0;
      sram_we_n = 1'b1;
      sram_addr = '0;
      dq_dat    = '0;
      err_exp   = 1'b0;
      wr_exp    = '0;
      rd_exp    = '0;
      cyc       = 0;
      n_chk     = 0;
      n_fail    = 0;
      repeat (3) step(1'b0, '0, '0);
      rst = 1'b1;

      // Known contents everywhere, written through aliased addresses.
      for (int i = 0; i < 2**MEM_AW; i++) begin
         step(1'b1, {ADDR_W'($urandom) & ~ADDR_W'(2**MEM_AW - 1)} | ADDR_W'(i), DATA_W'($urandom));
      end

      // Basic write/read.
      step(1'b1, 18'd5, 16'hBEEF);
      repeat (3) step(1'b0, 18'd5, '0);
      // Alias: 0x13 and 0x03 share a word.
      step(1'b1, 18'h00013, 16'h1234);
      repeat (3) step(1'b0, 18'h00003, '0);
      // Flush: read 7, write 9 next cycle, read 7 again.
      step(1'b1, 18'd7, 16'h7777);
      step(1'b0, 18'd7, '0);
      step(1'b1, 18'd9, 16'h0001);
      repeat (3) step(1'b0, 18'd7, '0);
      // Launch-time sampling.
      step(1'b1, 18'd3, 16'hAAAA);
      step(1'b0, 18'd3, '0);
      step(1'b1, 18'd3, 16'h5555);
      repeat (3) step(1'b0, 18'd3, '0);
      // Reset mid-read; the array must survive.
      step(1'b1, 18'd2, 16'hCAFE);
      step(1'b0, 18'd2, '0);
      do_reset(2);
      repeat (4) step(1'b0, 18'd2, '0);

      // Random traffic, including full-width aliased addresses.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 22, ADDR_W'($urandom), DATA_W'($urandom));
      end
      do_reset(1);

      // Long held read: counter must saturate, not wrap.
      repeat (66000) step(1'b0, 18'd1, '0);
      step(1'b1, 18'd1, 16'h0F0F);
      repeat (4) step(1'b0, 18'd1, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
